// File: rtl/ex_forward_ctrl.sv
// ex_forward_ctrl: EX-stage operand forwarding selects, load-use stall and stall counter
module ex_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  // MEM and WB only need dst/regwrite; their source fields and load flag are never consulted
  logic [REG_W-1:0] ex_rs_q, ex_rt_q, ex_dst_q, mem_dst_q, wb_dst_q;
  logic [REG_W-1:0] ex_rs_d, ex_rt_d, ex_dst_d;
  logic             ex_rw_q, ex_mr_q, mem_rw_q, wb_rw_q;
  logic             ex_rw_d, ex_mr_d, kill;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // newest producer wins; register 0 is hardwired and never forwarded
  function automatic logic [1:0] sel(input logic [REG_W-1:0] src);
    return (mem_rw_q && mem_dst_q != '0 && mem_dst_q == src) ? 2'd2 :
           (wb_rw_q  && wb_dst_q  != '0 && wb_dst_q  == src) ? 2'd1 : 2'd0;
  endfunction

  // forwarding selects, load-use detection, bubble insertion and saturating stall count
  always_comb begin
    forward_a_o = sel(ex_rs_q);
    forward_b_o = sel(ex_rt_q);
    stall_o     = ex_mr_q && ex_dst_q != '0 && (ex_dst_q == id_rs_i || ex_dst_q == id_rt_i);
    kill        = stall_o | flush_i;
    ex_rs_d     = kill ? '0 : id_rs_i;
    ex_rt_d     = kill ? '0 : id_rt_i;
    ex_dst_d    = kill ? '0 : id_dst_i;
    ex_rw_d     = kill ? 1'b0 : id_regwrite_i;
    ex_mr_d     = kill ? 1'b0 : id_memread_i;
    cnt_d       = (stall_o && !flush_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // pipeline slot advance; reset turns every slot into a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      ex_dst_q  <= '0;
      ex_rw_q   <= 1'b0;
      ex_mr_q   <= 1'b0;
      mem_dst_q <= '0;
      mem_rw_q  <= 1'b0;
      wb_dst_q  <= '0;
      wb_rw_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ex_rs_q   <= ex_rs_d;
      ex_rt_q   <= ex_rt_d;
      ex_dst_q  <= ex_dst_d;
      ex_rw_q   <= ex_rw_d;
      ex_mr_q   <= ex_mr_d;
      mem_dst_q <= ex_dst_q;
      mem_rw_q  <= ex_rw_q;
      wb_dst_q  <= mem_dst_q;
      wb_rw_q   <= mem_rw_q;
      cnt_q     <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;
endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb_ex_forward_ctrl: directed scoreboard bench for ex_forward_ctrl
module tb_ex_forward_ctrl;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs_i, id_rt_i, id_dst_i;
  logic       id_regwrite_i, id_memread_i, flush_i;
  logic [1:0] forward_a_o, forward_b_o;
  logic       stall_o;
  logic [1:0] stall_cnt_o;

  typedef struct {
    string      name;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic [1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  ex_forward_ctrl #(.REG_W(5), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_dst_i(id_dst_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .flush_i(flush_i), .forward_a_o(forward_a_o), .forward_b_o(forward_b_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic push(input string n, input logic [1:0] fa, fb, input logic st, input logic [1:0] cnt);
    exp_t e;
    e.name = n; e.fa = fa; e.fb = fb; e.st = st; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic drive(input logic [4:0] rs, rt, dst, input logic rw, mr, fl);
    id_rs_i = rs; id_rt_i = rt; id_dst_i = dst;
    id_regwrite_i = rw; id_memread_i = mr; flush_i = fl;
  endtask

  task automatic cyc(input string n, input logic [4:0] rs, rt, dst, input logic rw, mr, fl,
                     input logic [1:0] fa, fb, input logic st, input logic [1:0] cnt);
    @(posedge clk_i); #1;
    drive(rs, rt, dst, rw, mr, fl);
    push(n, fa, fb, st, cnt);
  endtask

  // monitor: outputs are sampled mid-cycle against the oldest pending expectation
  always @(negedge clk_i) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (forward_a_o !== e.fa || forward_b_o !== e.fb || stall_o !== e.st || stall_cnt_o !== e.cnt) begin
        errors++;
        $display("FAIL %s: got fa=%0d fb=%0d stall=%0d cnt=%0d, expected fa=%0d fb=%0d stall=%0d cnt=%0d",
                 e.name, forward_a_o, forward_b_o, stall_o, stall_cnt_o, e.fa, e.fb, e.st, e.cnt);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    cyc("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    push("reset_release", 0, 0, 0, 0);
    // ALU chain: add $8; sub rs=$8; and rt=$8
    cyc("alu_add8",   1, 2,  8, 1, 0, 0, 0, 0, 0, 0);
    cyc("alu_sub",    8, 3, 11, 1, 0, 0, 0, 0, 0, 0);
    cyc("alu_fwd_a2", 4, 8, 12, 1, 0, 0, 2, 0, 0, 0);
    cyc("alu_fwd_b1", 0, 0,  0, 0, 0, 0, 0, 1, 0, 0);
    // priority: $9 written twice, then read on both operands
    cyc("pri_w1",     1, 2,  9, 1, 0, 0, 0, 0, 0, 0);
    cyc("pri_w2",     3, 4,  9, 1, 0, 0, 0, 0, 0, 0);
    cyc("pri_rd",     9, 9, 13, 1, 0, 0, 0, 0, 0, 0);
    cyc("pri_mem2",   0, 0,  0, 0, 0, 0, 2, 2, 0, 0);
    // load-use: lw $10; add rs=$10 held one cycle
    cyc("lu_lw",      1, 10, 10, 1, 1, 0, 0, 0, 0, 0);
    cyc("lu_stall",  10, 5,  14, 1, 0, 0, 0, 0, 1, 0);
    cyc("lu_release",10, 5,  14, 1, 0, 0, 0, 0, 0, 1);
    cyc("lu_fwd_a1",  0, 0,   0, 0, 0, 0, 1, 0, 0, 1);
    // $zero is never forwarded
    cyc("zero_w",     1, 2,  0, 1, 0, 0, 0, 0, 0, 1);
    cyc("zero_rd",    0, 0, 15, 1, 0, 0, 0, 0, 0, 1);
    cyc("zero_none",  0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
    // flush in the stall cycle: bubble, count unchanged
    cyc("fl_lw",      0, 0, 16, 1, 1, 0, 0, 0, 0, 1);
    cyc("fl_stall",  16, 16, 17, 1, 0, 1, 0, 0, 1, 1);
    cyc("fl_nocnt",  16, 16, 17, 1, 0, 0, 0, 0, 0, 1);
    // repeated load-use pairs drive the 2-bit counter into saturation
    for (int k = 0; k < 3; k++) begin
      logic [4:0] d;
      logic [1:0] c0, c1;
      d  = 5'(20 + k);
      c0 = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd3;
      c1 = (k == 0) ? 2'd2 : 2'd3;
      cyc("sat_lw",    0, 0, d, 1, 1, 0, 1, (k == 0) ? 2'd1 : 2'd0, 0, c0);
      cyc("sat_stall", d, 0, 25, 1, 0, 0, 0, 0, 1, c0);
      cyc("sat_held",  d, 0, 25, 1, 0, 0, 0, 0, 0, c1);
    end
    // mid-stream reset while MEM.dst=8 matches EX.rs=8
    cyc("rs_add8",    1, 2, 8, 1, 0, 0, 1, 0, 0, 3);
    cyc("rs_sub",     8, 0, 9, 1, 0, 0, 0, 0, 0, 3);
    @(posedge clk_i); #1;
    drive(0, 0, 0, 0, 0, 0);
    #2 rst_i = 1'b1;
    push("rs_async", 0, 0, 0, 0);
    cyc("rs_held",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    push("rs_after", 0, 0, 0, 0);
    // tracking works again after reset
    cyc("post_lw",    0, 0, 3, 1, 1, 0, 0, 0, 0, 0);
    cyc("post_stall", 3, 0, 4, 1, 0, 0, 0, 0, 1, 0);
    cyc("post_cnt",   3, 0, 4, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk_i);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_forward_ctrl.md
# ex_forward_ctrl

Operand-forwarding and load-use hazard controller for the pipelined CPU's EX stage. It tracks the destination register, write-enable and load flag of each instruction as it moves ID→EX→MEM→WB. From that it generates the 2-bit select codes for the two EX-stage 3-to-1 operand muxes and a stall request for the ID stage. It also keeps a saturating count of stall cycles for performance debug.

## Interface
Parameters:
- REG_W, default 5, register-index width
- CNT_W, default 16, stall counter width

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- id_rs_i  in  REG_W  source register rs of the instruction in ID
- id_rt_i  in  REG_W  source register rt of the instruction in ID
- id_dst_i  in  REG_W  destination register of the instruction in ID (already resolved rd/rt)
- id_regwrite_i  in  1  instruction in ID writes the register file
- id_memread_i  in  1  instruction in ID is a load
- flush_i  in  1  squash the instruction entering EX (taken branch)
- forward_a_o  out  2  select for the EX operand-A mux
- forward_b_o  out  2  select for the EX operand-B mux
- stall_o  out  1  load-use stall request; upstream holds PC and IF/ID
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Internal slots EX, MEM and WB each hold {rs, rt, dst, regwrite, memread}. Only EX uses rs and rt.
- A bubble is a slot with every field 0.
- Slot advance on each clock edge:
  - WB ← MEM
  - MEM ← EX
  - EX ← bubble if (stall_o | flush_i), otherwise the id_* inputs
- Mux select encoding: 0 = register-file/ID-EX value, 1 = MEM/WB writeback data, 2 = EX/MEM ALU result. Code 3 is never driven.
- forward_a_o, combinational from the slots:
  - 2 if MEM.regwrite && MEM.dst≠0 && MEM.dst==EX.rs
  - else 1 if WB.regwrite && WB.dst≠0 && WB.dst==EX.rs
  - else 0
- forward_b_o: identical rule, using EX.rt.
- MEM has priority over WB, so the newest value wins.
- Register 0 is never forwarded.
- stall_o, combinational: EX.memread && EX.dst≠0 && (EX.dst==id_rs_i || EX.dst==id_rt_i). The rt comparison is always made; the resulting false stalls on I-type instructions are accepted.
- stall_cnt_o increments by 1 on each edge where stall_o=1 and flush_i=0. It holds at 2^CNT_W−1 and does not wrap.
- Same-cycle WB write and ID read of the same register is resolved by the register file (write-first). This block does not cover it.

## Timing
- Reset (asynchronous assert, value held while rst_i=1):
  - all slots become bubbles
  - forward_a_o = forward_b_o = 0, stall_o = 0, stall_cnt_o = 0
- Reset mid-operation discards all in-flight tracking immediately.
- forward_*_o and stall_o are valid in the same cycle as the slot contents and inputs they depend on. There is no added latency.
- A load-use pair produces exactly one stall cycle:
  - Cycle n: stall_o=1. A bubble enters EX at the next edge.
  - Cycle n+1: the load is in MEM and the dependent instruction (held in ID) is compared again. stall_o=0.
  - Cycle n+2: the dependent instruction is in EX and the load is in WB. Forward select = 1.
- flush_i and stall_o in the same cycle: EX receives a bubble and stall_cnt_o does not increment.
- flush_i affects only the EX slot. Instructions already in MEM and WB continue to retire.
- Back-to-back ALU dependency (producer in MEM, consumer in EX) gives select 2 with no stall.

## Test plan
- Reset: assert rst_i mid-stream with MEM.dst=8 matching EX.rs=8 → forward_a_o drops to 0 immediately; stall_cnt_o=0 after release.
- ALU chain: add $8 at ID, next cycle sub using rs=$8 → when sub is in EX, forward_a_o=2. One cycle later, with an independent instruction in EX reading rt=$8, forward_b_o=1. stall_o stays 0.
- Priority: write $9 twice consecutively, then read rs=rt=$9 → forward_a_o=forward_b_o=2 (MEM wins over WB).
- Load-use: lw $10 then add rs=$10 → stall_o=1 for exactly one cycle; stall_cnt_o 0→1; two cycles after the stall, forward_a_o=1.
- $zero: add writing $0 followed by a reader of $0 → both selects 0.
- Flush during stall, plus saturation:
  - flush_i=1 in the stall cycle → bubble in EX, stall_cnt_o unchanged.
  - With CNT_W=2, four stall cycles → stall_cnt_o sticks at 3.
